// File: rtl/mcu_hid_pkg.sv
// Shared opcodes, sizes and framer types for the MCU HID SPI receiver.
package mcu_hid_pkg;

  localparam logic [7:0] OP_KBD  = 8'h01;
  localparam logic [7:0] OP_MX   = 8'h0A;
  localparam logic [7:0] OP_MY   = 8'h0B;
  localparam logic [7:0] OP_MBTN = 8'h0C;
  localparam logic [7:0] OP_KJ   = 8'h0D;

  localparam int unsigned KBD_BYTES = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_SKIP
  } frm_state_t;

  typedef enum logic [2:0] {
    CMD_KBD,
    CMD_MX,
    CMD_MY,
    CMD_MBTN,
    CMD_KJ
  } cmd_t;

  // True for every opcode the framer knows how to handle.
  function automatic logic op_known(input logic [7:0] op);
    return (op == OP_KBD) || (op == OP_MX) || (op == OP_MY) ||
           (op == OP_MBTN) || (op == OP_KJ);
  endfunction

endpackage

// File: rtl/hid_spi_shift.sv
// SPI mode-0 slave bit layer: synchronises the raw pins into the core clock,
// detects sck/cs_n edges and assembles MSB-first bytes.
module hid_spi_shift #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       byte_vld,
  output logic [7:0] byte_data,
  output logic       cs_fall,
  output logic       cs_rise
);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic [SYNC_STAGES-1:0] cs_sync;

  logic       sck_s;
  logic       mosi_s;
  logic       cs_s;
  logic       sck_prev;
  logic       cs_prev;
  logic       sck_rise;
  logic [6:0] shreg;
  logic [2:0] bit_cnt;

  // Synchronisers. cs_n resets to 0 so a reset taken mid-frame (cs_n still
  // low) cannot manufacture a false falling edge; the next frame needs a real
  // high-to-low transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev;

  // Edge history, shifter, bit counter and registered byte/edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_prev  <= 1'b0;
      cs_prev   <= 1'b0;
      shreg     <= '0;
      bit_cnt   <= '0;
      byte_vld  <= 1'b0;
      byte_data <= '0;
      cs_fall   <= 1'b0;
      cs_rise   <= 1'b0;
    end else begin
      sck_prev <= sck_s;
      cs_prev  <= cs_s;
      byte_vld <= 1'b0;
      cs_fall  <= cs_prev & ~cs_s;
      cs_rise  <= cs_s & ~cs_prev;
      if (cs_s || cs_prev) begin
        // Deselected, or first selected cycle: drop any partial byte.
        shreg   <= '0;
        bit_cnt <= '0;
      end else if (sck_rise) begin
        shreg   <= {shreg[5:0], mosi_s};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_vld  <= 1'b1;
          byte_data <= {shreg, mosi_s};
        end
      end
    end
  end

endmodule

// File: rtl/mcu_hid_rx.sv
// Frames bytes from the MCU SPI link into keyboard / mouse / joystick load
// strobes with data held alongside.
module mcu_hid_rx
  import mcu_hid_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic [7:0] kbd_in,
  output logic [2:0] kbd_in_sel,
  output logic       kbd_stb,
  output logic [7:0] mus_in,
  output logic       mus_xstb,
  output logic       mus_ystb,
  output logic       mus_btnstb,
  output logic       kj_stb,
  output logic       frame_err
);

  logic       byte_vld;
  logic [7:0] rx_byte;
  logic       cs_fall;
  logic       cs_rise;

  frm_state_t state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [2:0] cnt_q, cnt_d;

  logic [7:0] kbd_in_d;
  logic [2:0] kbd_in_sel_d;
  logic       kbd_stb_d;
  logic [7:0] mus_in_d;
  logic       mus_xstb_d;
  logic       mus_ystb_d;
  logic       mus_btnstb_d;
  logic       kj_stb_d;
  logic       frame_err_d;

  hid_spi_shift #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_shift (
    .clk       (fclk),
    .rst_n     (rst_n),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_cs_n  (spi_cs_n),
    .byte_vld  (byte_vld),
    .byte_data (rx_byte),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  // Framer state, command and keyboard byte index.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_KBD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; a rising cs_n overrides everything, including a byte
  // completing in the same cycle.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (cs_fall) state_d = ST_CMD;
        ST_CMD: begin
          if (byte_vld) begin
            state_d = ST_DATA;
            case (rx_byte)
              OP_KBD:  begin cmd_d = CMD_KBD; cnt_d = '0; end
              OP_MX:   cmd_d = CMD_MX;
              OP_MY:   cmd_d = CMD_MY;
              OP_MBTN: cmd_d = CMD_MBTN;
              OP_KJ:   cmd_d = CMD_KJ;
              default: state_d = ST_SKIP;
            endcase
          end
        end
        ST_DATA: begin
          if (byte_vld) begin
            if (cmd_q == CMD_KBD) begin
              cnt_d = cnt_q + 3'd1;
              if (cnt_q == 3'(KBD_BYTES - 1)) state_d = ST_SKIP;
            end else begin
              state_d = ST_SKIP;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Output decode: strobes default low, data holds its last value.
  always_comb begin
    kbd_in_d     = kbd_in;
    kbd_in_sel_d = kbd_in_sel;
    kbd_stb_d    = 1'b0;
    mus_in_d     = mus_in;
    mus_xstb_d   = 1'b0;
    mus_ystb_d   = 1'b0;
    mus_btnstb_d = 1'b0;
    kj_stb_d     = 1'b0;
    frame_err_d  = 1'b0;
    if (cs_rise) begin
      frame_err_d = (state_q == ST_DATA);
    end else if (byte_vld) begin
      if (state_q == ST_CMD) begin
        frame_err_d = ~op_known(rx_byte);
      end else if (state_q == ST_DATA) begin
        case (cmd_q)
          CMD_KBD: begin
            kbd_in_d     = rx_byte;
            kbd_in_sel_d = cnt_q;
            kbd_stb_d    = 1'b1;
          end
          CMD_MX:   begin mus_in_d = rx_byte; mus_xstb_d   = 1'b1; end
          CMD_MY:   begin mus_in_d = rx_byte; mus_ystb_d   = 1'b1; end
          CMD_MBTN: begin mus_in_d = rx_byte; mus_btnstb_d = 1'b1; end
          CMD_KJ:   begin mus_in_d = rx_byte; kj_stb_d     = 1'b1; end
          default:  frame_err_d = 1'b0;
        endcase
      end
    end
  end

  // Registered outputs: strobes one cycle after the byte completes.
  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      kbd_in     <= '0;
      kbd_in_sel <= '0;
      kbd_stb    <= 1'b0;
      mus_in     <= '0;
      mus_xstb   <= 1'b0;
      mus_ystb   <= 1'b0;
      mus_btnstb <= 1'b0;
      kj_stb     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      kbd_in     <= kbd_in_d;
      kbd_in_sel <= kbd_in_sel_d;
      kbd_stb    <= kbd_stb_d;
      mus_in     <= mus_in_d;
      mus_xstb   <= mus_xstb_d;
      mus_ystb   <= mus_ystb_d;
      mus_btnstb <= mus_btnstb_d;
      kj_stb     <= kj_stb_d;
      frame_err  <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_mcu_hid_rx.sv
// Directed bench for mcu_hid_rx: drives SPI frames and checks strobes/data.
module tb_mcu_hid_rx;

  logic       fclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_sck = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic [7:0] kbd_in;
  logic [2:0] kbd_in_sel;
  logic       kbd_stb;
  logic [7:0] mus_in;
  logic       mus_xstb;
  logic       mus_ystb;
  logic       mus_btnstb;
  logic       kj_stb;
  logic       frame_err;

  mcu_hid_rx #(.SYNC_STAGES(2)) dut (
    .fclk       (fclk),
    .rst_n      (rst_n),
    .spi_sck    (spi_sck),
    .spi_mosi   (spi_mosi),
    .spi_cs_n   (spi_cs_n),
    .kbd_in     (kbd_in),
    .kbd_in_sel (kbd_in_sel),
    .kbd_stb    (kbd_stb),
    .mus_in     (mus_in),
    .mus_xstb   (mus_xstb),
    .mus_ystb   (mus_ystb),
    .mus_btnstb (mus_btnstb),
    .kj_stb     (kj_stb),
    .frame_err  (frame_err)
  );

  always #5 fclk = ~fclk;

  int tests = 0;
  int failed = 0;

  // Monitor state, sampled on the falling fclk edge.
  int         n_kbd = 0, n_mx = 0, n_my = 0, n_mb = 0, n_kj = 0;
  int         n_err = 0, n_multi = 0;
  logic [7:0] mx_val = '0, my_val = '0, mb_val = '0, kj_val = '0;
  logic [2:0] sel_log[$];
  logic [7:0] dat_log[$];
  realtime    t_sck = 0;
  realtime    last_lat = 0;

  always @(posedge spi_sck) t_sck = $realtime;

  always @(negedge fclk) begin
    if (rst_n) begin
      if ((32'(kbd_stb) + 32'(mus_xstb) + 32'(mus_ystb) + 32'(mus_btnstb) + 32'(kj_stb)) > 1)
        n_multi++;
      if (kbd_stb)    begin n_kbd++; sel_log.push_back(kbd_in_sel); dat_log.push_back(kbd_in); end
      if (mus_xstb)   begin n_mx++; mx_val = mus_in; end
      if (mus_ystb)   begin n_my++; my_val = mus_in; end
      if (mus_btnstb) begin n_mb++; mb_val = mus_in; end
      if (kj_stb)     begin n_kj++; kj_val = mus_in; end
      if (frame_err)  n_err++;
      if (kbd_stb || mus_xstb || mus_ystb || mus_btnstb || kj_stb)
        last_lat = $realtime - t_sck;
    end
  end

  function automatic int n_stb();
    return n_kbd + n_mx + n_my + n_mb + n_kj;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] b, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      spi_mosi = b[7-k];
      #80 spi_sck = 1'b1;
      #80 spi_sck = 1'b0;
    end
  endtask

  task automatic send_frame(input int n, input logic [63:0] data);
    spi_cs_n = 1'b0;
    #100;
    for (int i = 0; i < n; i++) spi_byte(data[8*(n-1-i) +: 8], 8);
    #100 spi_cs_n = 1'b1;
    #200;
  endtask

  int s_kbd, s_mx, s_my, s_mb, s_kj, s_err, s_stb;

  task automatic snap();
    s_kbd = n_kbd; s_mx = n_mx; s_my = n_my; s_mb = n_mb; s_kj = n_kj;
    s_err = n_err; s_stb = n_stb();
  endtask

  initial begin
    #1;
    chk("rst_kbd_in", 32'(kbd_in), 32'h00);
    chk("rst_kbd_sel", 32'(kbd_in_sel), 32'h0);
    chk("rst_mus_in", 32'(mus_in), 32'h00);
    chk("rst_strobes", 32'({kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb}), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    #21 rst_n = 1'b1;
    #100;

    // Keyboard frame: five bytes at indices 0..4.
    snap();
    send_frame(6, 64'h01_11_22_33_44_55);
    chk("kbd_count", 32'(n_kbd - s_kbd), 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk("kbd_sel", 32'(sel_log[i]), 32'(i));
    end
    chk("kbd_dat0", 32'(dat_log[0]), 32'h11);
    chk("kbd_dat1", 32'(dat_log[1]), 32'h22);
    chk("kbd_dat2", 32'(dat_log[2]), 32'h33);
    chk("kbd_dat3", 32'(dat_log[3]), 32'h44);
    chk("kbd_dat4", 32'(dat_log[4]), 32'h55);
    chk("kbd_no_err", 32'(n_err - s_err), 32'd0);
    chk("latency_window", 32'((last_lat >= 30) && (last_lat <= 55)), 32'd1);
    chk("kbd_hold_data", 32'(kbd_in), 32'h55);

    // Mouse / joystick single-byte frames.
    snap();
    send_frame(2, 64'h0A_7F);
    send_frame(2, 64'h0B_80);
    send_frame(2, 64'h0C_F5);
    send_frame(2, 64'h0D_1F);
    chk("mx_count", 32'(n_mx - s_mx), 32'd1);
    chk("my_count", 32'(n_my - s_my), 32'd1);
    chk("mb_count", 32'(n_mb - s_mb), 32'd1);
    chk("kj_count", 32'(n_kj - s_kj), 32'd1);
    chk("mx_val", 32'(mx_val), 32'h7F);
    chk("my_val", 32'(my_val), 32'h80);
    chk("mb_val", 32'(mb_val), 32'hF5);
    chk("kj_val", 32'(kj_val), 32'h1F);
    chk("mus_no_err", 32'(n_err - s_err), 32'd0);
    chk("mus_no_kbd", 32'(n_kbd - s_kbd), 32'd0);

    // Trailing bytes after a mouse byte are ignored.
    snap();
    send_frame(4, 64'h0A_10_20_30);
    chk("trail_stb_total", 32'(n_stb() - s_stb), 32'd1);
    chk("trail_mx_count", 32'(n_mx - s_mx), 32'd1);
    chk("trail_mx_val", 32'(mx_val), 32'h10);
    chk("trail_no_err", 32'(n_err - s_err), 32'd0);

    // Unknown opcode.
    snap();
    send_frame(2, 64'h5A_12);
    chk("badop_err", 32'(n_err - s_err), 32'd1);
    chk("badop_no_stb", 32'(n_stb() - s_stb), 32'd0);

    // Short keyboard frame: cs_n rises 3 bits into the fourth byte.
    snap();
    spi_cs_n = 1'b0;
    #100;
    spi_byte(8'h01, 8);
    spi_byte(8'hAA, 8);
    spi_byte(8'hBB, 8);
    spi_byte(8'hCC, 3);
    #60 spi_cs_n = 1'b1;
    #200;
    chk("short_kbd_count", 32'(n_kbd - s_kbd), 32'd2);
    chk("short_sel0", 32'(sel_log[5]), 32'd0);
    chk("short_dat0", 32'(dat_log[5]), 32'hAA);
    chk("short_sel1", 32'(sel_log[6]), 32'd1);
    chk("short_dat1", 32'(dat_log[6]), 32'hBB);
    chk("short_err", 32'(n_err - s_err), 32'd1);

    snap();
    send_frame(2, 64'h0B_04);
    chk("after_short_my", 32'(n_my - s_my), 32'd1);
    chk("after_short_val", 32'(my_val), 32'h04);
    chk("after_short_no_err", 32'(n_err - s_err), 32'd0);

    // Reset asserted mid-byte of a keyboard frame.
    snap();
    spi_cs_n = 1'b0;
    #100;
    spi_byte(8'h01, 8);
    spi_byte(8'h11, 4);
    #40 rst_n = 1'b0;
    #1;
    chk("midrst_kbd_in", 32'(kbd_in), 32'h00);
    chk("midrst_kbd_sel", 32'(kbd_in_sel), 32'h0);
    chk("midrst_mus_in", 32'(mus_in), 32'h00);
    chk("midrst_strobes", 32'({kbd_stb, mus_xstb, mus_ystb, mus_btnstb, kj_stb, frame_err}), 32'h0);
    #19 spi_cs_n = 1'b1;
    #20 rst_n = 1'b1;
    #200;
    send_frame(2, 64'h0D_03);
    chk("postrst_kj", 32'(n_kj - s_kj), 32'd1);
    chk("postrst_kj_val", 32'(kj_val), 32'h03);
    chk("postrst_stb_total", 32'(n_stb() - s_stb), 32'd1);
    chk("postrst_no_err", 32'(n_err - s_err), 32'd0);

    chk("one_hot_strobes", 32'(n_multi), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mcu_hid_rx.md
# mcu_hid_rx

SPI slave front end that receives keyboard matrix, mouse and joystick frames from the board microcontroller and turns them into the byte-plus-strobe bus consumed by the keyboard/mouse multiplexer in the TSConf core. It synchronises the raw SPI pins into the `fclk` domain, deframes command and data bytes, and issues single-cycle load strobes with the data held stable alongside.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchroniser depth for `spi_sck`, `spi_mosi` and `spi_cs_n`; minimum 2.

Ports:
- `fclk`  in  1  core clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `spi_sck`  in  1  raw SPI clock from MCU, mode 0; asynchronous to `fclk`.
- `spi_mosi`  in  1  raw SPI data, MSB first.
- `spi_cs_n`  in  1  raw frame select, active-low.
- `kbd_in`  out  8  keyboard byte; 1 = key pressed.
- `kbd_in_sel`  out  3  keyboard byte index, 0..4.
- `kbd_stb`  out  1  one-cycle load strobe for `kbd_in` at `kbd_in_sel`.
- `mus_in`  out  8  mouse/joystick data byte.
- `mus_xstb`, `mus_ystb`, `mus_btnstb`, `kj_stb`  out  1 each  one-cycle load strobes qualifying `mus_in`.
- `frame_err`  out  1  one-cycle pulse on an unknown command or a short frame.

## Operation
- All three SPI inputs pass through `SYNC_STAGES` flops. Edge detection runs on the last two synchronised `spi_sck` samples. `mosi` is shifted in on each detected rising edge only while the synchronised `cs_n` is 0.
- The bit counter is 3 bits wide. On the 8th rising edge, the byte is complete and is handed to the framer. The counter wraps to 0.
- Framer states:
  - IDLE: synchronised `cs_n` = 1. On a falling `cs_n`, clear the shifter and bit counter, then go to CMD.
  - CMD: first byte of the frame is the opcode.
    - `0x01` KBD: byte_cnt←0, go to DATA.
    - `0x0A` MX, `0x0B` MY, `0x0C` MBTN, `0x0D` KJ: go to DATA.
    - Any other opcode: pulse `frame_err`, go to SKIP.
  - DATA:
    - KBD: each byte drives `kbd_in`=byte, `kbd_in_sel`=byte_cnt, and pulses `kbd_stb`; byte_cnt increments. After byte_cnt 4, go to SKIP.
    - MX/MY/MBTN/KJ: the single byte drives `mus_in` and pulses the matching strobe, then go to SKIP.
  - SKIP: further bytes are ignored until `cs_n` rises.
- Rising `cs_n` in any state returns the framer to IDLE and discards any partial byte.
  - If the framer is in DATA at that point (command received, data incomplete), pulse `frame_err`.
  - Strobes already issued in the frame remain valid.
- `cs_n` rising on the same cycle as a byte completion: the byte is discarded, no strobe is issued, and `frame_err` follows the DATA rule above.
- Data outputs hold their last value between strobes. At most one strobe is high in any cycle.

## Timing
- Reset values: all strobes, `frame_err`, `kbd_in`, `kbd_in_sel` and `mus_in` are 0. Framer is in IDLE; shifter and counters are 0.
- Strobe latency: asserted exactly 1 `fclk` cycle after the synchronised edge detect of the 8th `sck` rising edge. That is `SYNC_STAGES`+2 cycles after the raw edge, ±1 cycle of synchroniser uncertainty.
- Strobe width: exactly 1 `fclk` cycle. Data is valid in the same cycle and stays valid at least until the next strobe.
- `fclk` must be at least 8× `sck`; the MCU leaves at least 4 `fclk` cycles between a `cs_n` edge and the first or last `sck` edge.
- Reset asserted mid-frame clears everything immediately. The frame in progress is lost and the next frame requires a fresh `cs_n` fall.

## Structure
- Package `mcu_hid_pkg`: opcode constants (KBD, MX, MY, MBTN, KJ), `KBD_BYTES`=5, and the framer state enum.
- Sub-module `hid_spi_shift`: synchronisers, edge detect, shifter and bit counter. Outputs `byte_vld`, `byte`, `cs_fall` and `cs_rise`.
- The framer lives in the top level.

## Test plan
- Frame 01 11 22 33 44 55 → five `kbd_stb` pulses with (sel,data) = (0,11),(1,22),(2,33),(3,44),(4,55); no `frame_err`.
- Frames 0A 7F, 0B 80, 0C F5, 0D 1F → exactly one pulse each of `mus_xstb`, `mus_ystb`, `mus_btnstb`, `kj_stb` with `mus_in` = 7F/80/F5/1F.
- Frame 0A 10 20 30 → only one `mus_xstb`, with `mus_in`=10; trailing bytes produce no strobe.
- Frame 5A 12 → one `frame_err` pulse after the first byte; no data strobe.
- Frame 01 AA BB, then `cs_n` high after 3 bits of the next byte → two `kbd_stb` pulses (sel 0,1), then one `frame_err`. The next frame 0B 04 works normally, with `mus_ystb` and `mus_in`=04.
- `rst_n` pulsed low mid-byte of a KBD frame → all outputs 0 at once. A following full frame 0D 03 yields `kj_stb` with `mus_in`=03.
